dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single DMEM port between the single-cycle CPU and a second word-transfer master (boot loader / debug DMA).
- Sits between CPU, DMEM and the secondary master inside the top-level computer.
- CPU has default priority; a bounded-wait counter guarantees secondary-master progress by stalling the CPU for one cycle.
- DMEM write is clocked and read is combinational; this block adds no latency on the CPU path.

Parameters:
- MAX_WAIT, 8: maximum cycles a granted DMA access defers to CPU traffic before the CPU is stalled. 0 means DMA is never deferred.
- CW, $clog2(MAX_WAIT+1) with minimum 1: wait counter width (derived, not overridden).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active high
cpu_rena  in  1  CPU read enable
cpu_wena  in  1  CPU write enable
cpu_select  in  2  CPU access size, passed to DMEM unchanged
cpu_addr  in  32  CPU data address
cpu_wdata  in  32  CPU write data
cpu_rdata  out  32  read data to CPU (= mem_rdata)
cpu_stall  out  1  CPU must hold PC and suppress register/memory writes this cycle
dma_req_valid  in  1  DMA request valid
dma_req_ready  out  1  arbiter accepts request
dma_we  in  1  1 = write, 0 = read
dma_select  in  2  DMA access size
dma_addr  in  32  DMA address
dma_wdata  in  32  DMA write data
dma_resp_valid  out  1  DMA access complete; dma_rdata valid for reads
dma_resp_ready  in  1  DMA consumes response
dma_rdata  out  32  captured read data
mem_rena, mem_wena  out  1 each  to DMEM
mem_select  out  2  to DMEM
mem_addr  out  32  to DMEM
mem_wdata  out  32  to DMEM
mem_rdata  in  32  from DMEM

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE, wait_cnt 0, dma_resp_valid 0, dma_rdata 0, latched request registers 0.
- Combinational outputs during reset: cpu_stall 0, dma_req_ready 0, mem_rena 0, mem_wena 0.
- cpu_active = cpu_rena | cpu_wena.
- dma_go = (state==GRANT) & (~cpu_active | wait_cnt==MAX_WAIT).
- Port mux: dma_go=1 drives mem_* from latched DMA registers; otherwise mem_* = cpu_*. mem_rena = ~dma_we_q and mem_wena = dma_we_q when DMA drives.
- cpu_stall = dma_go & cpu_active. It is combinational and never asserted outside GRANT.

States:
- IDLE: dma_req_ready=1. On dma_req_valid, latch we/select/addr/wdata, clear wait_cnt, go to GRANT.
- GRANT, dma_go=0: CPU owns the port, wait_cnt++, stay in GRANT.
- GRANT, dma_go=1: access performed this cycle. Write commits at the clock edge. For reads, mem_rdata is captured into dma_rdata at the edge; for writes, dma_rdata holds its old value. Set dma_resp_valid and go to RESP.
- RESP: dma_resp_valid=1 and dma_rdata stable. CPU owns the port unconditionally. On dma_resp_ready go to IDLE and clear dma_resp_valid.
- dma_req_ready is 0 in GRANT and RESP.

Boundary conditions:
- Minimum DMA latency, accept to resp_valid: 2 cycles (accept edge, then access edge).
- Maximum latency: MAX_WAIT+2 cycles.
- Back-to-back DMA requests: at least 3 cycles apart.
- MAX_WAIT=0: dma_go is always 1 in GRANT; the CPU is stalled if it is active.
- wait_cnt saturates at MAX_WAIT and never wraps.
- DMA write and CPU write never commit in the same cycle.
- Reset asserted in GRANT: no DMEM write that cycle; the request is dropped and no response is issued.
- Reset asserted in RESP: the response is dropped.
- dma_* inputs are ignored outside IDLE-accept.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined: adds outputs stat_dma_xfers[31:0] (increments each dma_go cycle) and stat_stall_cycles[31:0] (increments each cpu_stall cycle). Both are wrap-around counters cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- CPU idle; DMA write addr 0x10, data 0xDEADBEEF, select 2'b00 at cycle 0 -> mem_wena=1 with DMA addr/data in cycle 1; dma_resp_valid=1 in cycle 2; cpu_stall never 1; a later CPU read of 0x10 returns 0xDEADBEEF.
- CPU issues loads every cycle; DMA read of 0x10 with MAX_WAIT=8 -> CPU owns the port for 8 GRANT cycles; cpu_stall=1 for exactly 1 cycle; dma_rdata=0xDEADBEEF; resp_valid 10 cycles after accept.
- MAX_WAIT=0, CPU storing continuously, DMA write -> cpu_stall=1 in the cycle after accept; only the DMA word is written that cycle; CPU stores before and after are intact.
- dma_resp_ready held 0 for 5 cycles -> dma_resp_valid and dma_rdata stable; dma_req_ready=0 throughout; CPU accesses pass through unaltered.
- rst asserted during GRANT of a DMA write to 0x20 (previously 0x0) -> 0x20 still reads 0x0; state IDLE; dma_resp_valid=0; cpu_stall=0.
- With DMEM_ARB_STATS_EN: run scenario 2 -> stat_dma_xfers=1, stat_stall_cycles=1; rst clears both to 0.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: CPU, DMA and DMEM signals around the DMEM port arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface dmem_port_arbiter_if;
    logic        cpu_rena, cpu_wena, cpu_stall;
    logic [1:0]  cpu_select;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req_valid, dma_req_ready, dma_we, dma_resp_valid, dma_resp_ready;
    logic [1:0]  dma_select;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_rena, mem_wena;
    logic [1:0]  mem_select;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    modport slave (
        input  cpu_rena, cpu_wena, cpu_select, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req_valid, dma_we, dma_select, dma_addr, dma_wdata, dma_resp_ready,
        output dma_req_ready, dma_resp_valid, dma_rdata,
        output mem_rena, mem_wena, mem_select, mem_addr, mem_wdata,
        input  mem_rdata
    );
    modport master (
        output cpu_rena, cpu_wena, cpu_select, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req_valid, dma_we, dma_select, dma_addr, dma_wdata, dma_resp_ready,
        input  dma_req_ready, dma_resp_valid, dma_rdata,
        input  mem_rena, mem_wena, mem_select, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the DMEM port between the CPU (default priority) and a DMA master.
// Define DMEM_ARB_STATS_EN to add the stat_dma_xfers / stat_stall_cycles counters.
module dmem_port_arbiter #(
    parameter int MAX_WAIT = 8,
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
    input logic clk,
    input logic rst,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0] stat_dma_xfers,
    output logic [31:0] stat_stall_cycles,
`endif
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          we_q, we_d, resp_valid_q, resp_valid_d;
    logic [1:0]    sel_q, sel_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic          cpu_active, dma_go;

    // Reset masks every enable so a DMA access pending in GRANT never commits.
    always_comb begin
        cpu_active         = bus.cpu_rena | bus.cpu_wena;
        dma_go             = ~rst & (state_q == GRANT) & (~cpu_active | (wait_cnt_q == CW'(MAX_WAIT)));
        bus.cpu_stall      = dma_go & cpu_active;
        bus.cpu_rdata      = bus.mem_rdata;
        bus.dma_req_ready  = ~rst & (state_q == IDLE);
        bus.dma_resp_valid = resp_valid_q;
        bus.dma_rdata      = rdata_q;
        bus.mem_rena       = ~rst & (dma_go ? ~we_q : bus.cpu_rena);
        bus.mem_wena       = ~rst & (dma_go ? we_q : bus.cpu_wena);
        bus.mem_select     = dma_go ? sel_q : bus.cpu_select;
        bus.mem_addr       = dma_go ? addr_q : bus.cpu_addr;
        bus.mem_wdata      = dma_go ? wdata_q : bus.cpu_wdata;
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        we_d         = we_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: if (bus.dma_req_valid) begin
                we_d       = bus.dma_we;
                sel_d      = bus.dma_select;
                addr_d     = bus.dma_addr;
                wdata_d    = bus.dma_wdata;
                wait_cnt_d = '0;
                state_d    = GRANT;
            end
            GRANT: if (dma_go) begin
                rdata_d      = we_q ? rdata_q : bus.mem_rdata;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end else begin
                wait_cnt_d = wait_cnt_q + CW'(1);
            end
            RESP: if (bus.dma_resp_ready) begin
                resp_valid_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            we_q         <= 1'b0;
            sel_q        <= 2'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            rdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] xfers_q, xfers_d, stalls_q, stalls_d;
    always_comb begin
        xfers_d  = xfers_q + {31'b0, dma_go};
        stalls_d = stalls_q + {31'b0, bus.cpu_stall};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            xfers_q  <= 32'h0;
            stalls_q <= 32'h0;
        end else begin
            xfers_q  <= xfers_d;
            stalls_q <= stalls_d;
        end
    end
    assign stat_dma_xfers    = xfers_q;
    assign stat_stall_cycles = stalls_q;
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized checks of dmem_port_arbiter against a
// transaction-level model (golden memory, deadline-based DMA access cycle).
module tb_dmem_port_arbiter;
    localparam int MW = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_port_arbiter_if bus ();
    dmem_port_arbiter_if b0 ();

    logic [31:0] dmem [16] = '{default: 32'h0};
    logic [31:0] gold [16] = '{default: 32'h0};
    int tests = 0, fails = 0, xf_m = 0, st_m = 0;
    logic        m_we;
    logic [1:0]  m_sel;
    logic [31:0] m_addr, m_wdata, m_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] sx, ss, sx0, ss0;
`endif

    dmem_port_arbiter #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
`ifdef DMEM_ARB_STATS_EN
        .stat_dma_xfers(sx), .stat_stall_cycles(ss),
`endif
        .bus(bus));

    dmem_port_arbiter #(.MAX_WAIT(0)) dut0 (
        .clk(clk), .rst(rst),
`ifdef DMEM_ARB_STATS_EN
        .stat_dma_xfers(sx0), .stat_stall_cycles(ss0),
`endif
        .bus(b0));

    always @(posedge clk) if (bus.mem_wena) dmem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    assign bus.mem_rdata = dmem[bus.mem_addr[5:2]];
    assign b0.mem_rdata  = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 idle, 1 load, 2 store, 3 random mix
    task automatic drive_cpu(input int mode);
        int r;
        r = (mode == 3) ? $urandom_range(0, 3) : mode;
        bus.cpu_rena   = (r == 1);
        bus.cpu_wena   = (r == 2);
        bus.cpu_select = 2'($urandom);
        bus.cpu_addr   = {26'h0, 4'($urandom), 2'b00};
        bus.cpu_wdata  = $urandom;
    endtask

    task automatic garbage_dma();
        bus.dma_req_valid  = 1'($urandom);
        bus.dma_we         = 1'($urandom);
        bus.dma_select     = 2'($urandom);
        bus.dma_addr       = $urandom;
        bus.dma_wdata      = $urandom;
        bus.dma_resp_ready = 1'b0;
    endtask

    // One clock of checks; go = the model says DMA owns the port this cycle.
    task automatic cycle(input bit go, input bit rdy, input bit rv);
        logic act;
        int ci;
        #4;
        act = bus.cpu_rena | bus.cpu_wena;
        ci  = int'(bus.cpu_addr[5:2]);
        chk("cpu_stall", bus.cpu_stall, go & act);
        chk("req_ready", bus.dma_req_ready, rdy);
        chk("resp_valid", bus.dma_resp_valid, rv);
        chk("dma_rdata", bus.dma_rdata, m_rdata);
        chk("mem_rena", bus.mem_rena, go ? !m_we : bus.cpu_rena);
        chk("mem_wena", bus.mem_wena, go ? m_we : bus.cpu_wena);
        chk("mem_select", bus.mem_select, go ? m_sel : bus.cpu_select);
        chk("mem_addr", bus.mem_addr, go ? m_addr : bus.cpu_addr);
        chk("mem_wdata", bus.mem_wdata, go ? m_wdata : bus.cpu_wdata);
        if (bus.cpu_rena && !(go && act)) chk("cpu_rdata", bus.cpu_rdata, gold[ci]);
        if (go) begin
            xf_m++;
            st_m += int'(act);
            if (m_we) gold[m_addr[5:2]] = m_wdata;
            else m_rdata = gold[m_addr[5:2]];
        end else if (bus.cpu_wena) begin
            gold[ci] = bus.cpu_wdata;
        end
        tick();
    endtask

    task automatic idle_cycle(input int mode);
        bus.dma_req_valid  = 1'b0;
        bus.dma_resp_ready = 1'($urandom);
        drive_cpu(mode);
        cycle(0, 1, 0);
    endtask

    // Whole DMA transaction: accept, deferral up to MW cycles, access, response hold.
    task automatic xfer(input bit we, input logic [31:0] a, input logic [31:0] d, input int mode,
                        input int rdelay, output int lat, output int stl);
        int k = 0;
        int s0 = st_m;
        bit go = 1'b0;
        bus.dma_req_valid  = 1'b1;
        bus.dma_we         = we;
        bus.dma_select     = 2'($urandom);
        bus.dma_addr       = a;
        bus.dma_wdata      = d;
        bus.dma_resp_ready = 1'($urandom);
        m_we = we; m_sel = bus.dma_select; m_addr = a; m_wdata = d;
        drive_cpu(mode);
        cycle(0, 1, 0);
        while (!go) begin
            garbage_dma();
            drive_cpu(mode);
            go = !(bus.cpu_rena || bus.cpu_wena) || k == MW;
            cycle(go, 0, 0);
            k++;
        end
        lat = k + 1;
        stl = st_m - s0;
        for (int i = 0; i <= rdelay; i++) begin
            garbage_dma();
            bus.dma_resp_ready = (i == rdelay);
            drive_cpu(mode == 0 ? 0 : 3);
            cycle(0, 0, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, stl;
        bus.dma_req_valid = 1'b1; bus.dma_we = 1'b1; bus.dma_select = 2'b0;
        bus.dma_addr = 32'h0; bus.dma_wdata = 32'h0; bus.dma_resp_ready = 1'b0;
        bus.cpu_rena = 1'b1; bus.cpu_wena = 1'b1; bus.cpu_select = 2'b0;
        bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
        b0.dma_req_valid = 1'b0; b0.dma_we = 1'b0; b0.dma_select = 2'b0;
        b0.dma_addr = 32'h0; b0.dma_wdata = 32'h0; b0.dma_resp_ready = 1'b1;
        b0.cpu_rena = 1'b0; b0.cpu_wena = 1'b0; b0.cpu_select = 2'b0;
        b0.cpu_addr = 32'h0; b0.cpu_wdata = 32'h0;
        m_we = 1'b0; m_sel = 2'b0; m_addr = 32'h0; m_wdata = 32'h0; m_rdata = 32'h0;
        tick();
        #4;
        chk("rst_stall", bus.cpu_stall, 1'b0);
        chk("rst_req_ready", bus.dma_req_ready, 1'b0);
        chk("rst_mem_rena", bus.mem_rena, 1'b0);
        chk("rst_mem_wena", bus.mem_wena, 1'b0);
        chk("rst_resp_valid", bus.dma_resp_valid, 1'b0);
        chk("rst_dma_rdata", bus.dma_rdata, 32'h0);
        tick();
        rst = 1'b0;
        idle_cycle(0);

        // DMA write with idle CPU: minimum latency, no stall
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 0, lat, stl);
        chk("s1_latency", lat, 2);
        chk("s1_stalls", stl, 0);
        bus.dma_req_valid = 1'b0;
        bus.cpu_rena = 1'b1; bus.cpu_wena = 1'b0; bus.cpu_addr = 32'h10;
        #1;
        chk("s1_cpu_readback", bus.cpu_rdata, 32'hDEADBEEF);
        cycle(0, 1, 0);

        // DMA read under continuous CPU loads: full deferral then one stall
        xfer(1'b0, 32'h10, 32'h0, 1, 0, lat, stl);
        chk("s2_latency", lat, MW + 2);
        chk("s2_stalls", stl, 1);
        #1;
        chk("s2_dma_rdata", bus.dma_rdata, 32'hDEADBEEF);
`ifdef DMEM_ARB_STATS_EN
        chk("s2_stat_xfers", sx, xf_m);
        chk("s2_stat_stalls", ss, st_m);
`endif

        // MAX_WAIT=0 instance: continuous CPU stores, DMA write preempts immediately
        drive_cpu(0);
        bus.dma_req_valid = 1'b0;
        b0.cpu_wena = 1'b1; b0.cpu_addr = 32'h4; b0.cpu_wdata = 32'h1111;
        b0.dma_req_valid = 1'b1; b0.dma_we = 1'b1; b0.dma_addr = 32'h10; b0.dma_wdata = 32'h2222;
        #4;
        chk("mw0_acc_ready", b0.dma_req_ready, 1'b1);
        chk("mw0_acc_stall", b0.cpu_stall, 1'b0);
        chk("mw0_acc_addr", b0.mem_addr, 32'h4);
        chk("mw0_acc_wena", b0.mem_wena, 1'b1);
        tick();
        b0.dma_req_valid = 1'b0; b0.cpu_wdata = 32'h3333;
        #4;
        chk("mw0_go_stall", b0.cpu_stall, 1'b1);
        chk("mw0_go_addr", b0.mem_addr, 32'h10);
        chk("mw0_go_wdata", b0.mem_wdata, 32'h2222);
        chk("mw0_go_wena", b0.mem_wena, 1'b1);
        tick();
        b0.cpu_wdata = 32'h4444;
        #4;
        chk("mw0_resp_stall", b0.cpu_stall, 1'b0);
        chk("mw0_resp_valid", b0.dma_resp_valid, 1'b1);
        chk("mw0_resp_addr", b0.mem_addr, 32'h4);
        chk("mw0_resp_wdata", b0.mem_wdata, 32'h4444);
        tick();
        b0.cpu_wena = 1'b0;

        // Reset while a DMA write to 0x20 sits in GRANT
        bus.dma_req_valid = 1'b1; bus.dma_we = 1'b1; bus.dma_select = 2'b0;
        bus.dma_addr = 32'h20; bus.dma_wdata = 32'hCAFEF00D;
        m_we = 1'b1; m_sel = 2'b0; m_addr = 32'h20; m_wdata = 32'hCAFEF00D;
        drive_cpu(0);
        cycle(0, 1, 0);
        garbage_dma();
        drive_cpu(0);
        rst = 1'b1;
        #4;
        chk("rg_mem_wena", bus.mem_wena, 1'b0);
        chk("rg_stall", bus.cpu_stall, 1'b0);
        tick();
        rst = 1'b0; xf_m = 0; st_m = 0; m_rdata = 32'h0;
        bus.dma_req_valid = 1'b0;
        bus.cpu_rena = 1'b1; bus.cpu_wena = 1'b0; bus.cpu_addr = 32'h20;
        #1;
        chk("rg_idle_ready", bus.dma_req_ready, 1'b1);
        chk("rg_resp_valid", bus.dma_resp_valid, 1'b0);
        chk("rg_cpu_read", bus.cpu_rdata, 32'h0);
        chk("rg_dmem", dmem[8], 32'h0);
        cycle(0, 1, 0);

        // Response held for 5 cycles under random CPU traffic
        xfer(1'b0, 32'h10, 32'h0, 3, 5, lat, stl);

        // Randomized transactions, including back-to-back requests
        for (int n = 0; n < 25; n++) begin
            xfer(1'($urandom), {26'h0, 4'($urandom), 2'b00}, $urandom, 3, $urandom_range(0, 3), lat, stl);
            chk("rand_latency_bound", (lat >= 2 && lat <= MW + 2), 1'b1);
            for (int j = $urandom_range(0, 2); j > 0; j--) idle_cycle(3);
        end

`ifdef DMEM_ARB_STATS_EN
        chk("stat_xfers", sx, xf_m);
        chk("stat_stalls", ss, st_m);
        rst = 1'b1;
        tick();
        chk("stat_xfers_rst", sx, 32'h0);
        chk("stat_stalls_rst", ss, 32'h0);
        rst = 1'b0;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
